nibble_serial_alu: RTL and testbench
====================================

# nibble_serial_alu

Multi-cycle, parametrised ALU that evaluates a WIDTH-bit operation one SLICE_W-bit slice per clock. It reuses a single 74x381-style slice and chains the carry between slices through a register. It gives the CPU datapath an N-bit ALU with carry, overflow and zero flags at the cost of one physical slice. Requests use a start/busy/done handshake. The result and flags are held stable between operations.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a multiple of SLICE_W, ≥ SLICE_W.
- SLICE_W, 4, bits processed per cycle; NSLICE = WIDTH/SLICE_W.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request; accepted only on an edge where busy=0.
- op  in  3  function select, sampled on accept: 000 clear, 001 B−A, 010 A−B, 011 A+B, 100 XOR, 101 OR, 110 AND, 111 set-all-ones.
- a  in  WIDTH  operand A, sampled on accept.
- b  in  WIDTH  operand B, sampled on accept.
- cin  in  1  carry-in, sampled on accept. For add it is the carry. For subtract it is not-borrow: 1 means plain difference.
- busy  out  1  high while slices are being processed.
- done  out  1  one-cycle pulse; f and flags are valid from this cycle on.
- f  out  WIDTH  result register.
- cout  out  1  carry out of the MSB slice. For subtract, 1 means no borrow.
- ovf  out  1  two's-complement overflow.
- zero  out  1  high when f == 0.

## Operation
- States are IDLE, RUN and DONE. Reset enters IDLE.
- **IDLE/DONE → RUN:** taken when start=1.
  - Latch a, b, op and cin.
  - Carry register ← cin.
  - Slice index ← 0.
  - Latch the MSBs of a and b for the overflow calculation.
- **RUN:** each cycle evaluates slice `idx`, taking the low SLICE_W bits of the operand shift registers and the carry register.
  - A+B: a + b + c.
  - A−B: a + ~b + c.
  - B−A: b + ~a + c.
  - Carry register ← bit SLICE_W of the (SLICE_W+1)-bit sum.
  - The slice result shifts into the top of an internal accumulator.
  - Operands shift right by SLICE_W.
- **Logic ops, clear, set:** evaluated per slice the same way, with the carry register forced to 0.
- **RUN → DONE:** after slice NSLICE−1.
  - f ← accumulator.
  - cout ← final carry (0 for non-arithmetic ops).
  - zero ← (result == 0).
  - ovf, arithmetic ops only, else 0:
    - A+B: a_msb==b_msb && f_msb!=a_msb.
    - A−B: a_msb!=b_msb && f_msb!=a_msb.
    - B−A: a_msb!=b_msb && f_msb!=b_msb.
- **DONE → IDLE:** when start=0. A start in DONE is accepted, giving back-to-back operation.
- start while busy=1 is ignored; nothing is queued.
- f, cout, ovf and zero change only on entry to DONE. During RUN they hold the previous result.

## Timing
- Latency is uniform for all ops. With start accepted at edge k:
  - busy=1 for cycles k+1 … k+NSLICE.
  - done=1 for cycle k+NSLICE+1 only.
- Throughput is one operation per NSLICE+1 cycles.
- busy and done are registered state decodes: busy = (state==RUN), done = (state==DONE). There is no combinational path from inputs to outputs.
- Reset: rst_n low forces asynchronously state=IDLE and busy=done=cout=ovf=zero=0, f=0. This also applies mid-RUN: the operation is abandoned and no done is produced.
- Slice index wraps only by leaving RUN; it never exceeds NSLICE−1.

## Structure
- Shared package `alu_pkg`:
  - op code constants OP_CLR, OP_BSA, OP_ASB, OP_ADD, OP_XOR, OP_OR, OP_AND, OP_SET.
  - state encoding IDLE/RUN/DONE.
  - The 74x381 model and future ALU blocks use the same op constants.
- Sub-module `alu_slice`: combinational, SLICE_W-bit, inputs (a, b, op, c), outputs (f, cout), implementing the op table above. It is instantiated once.

## Test plan
All scenarios use WIDTH=16, SLICE_W=4.
- Add with cin=0: op=011, a=0x1234, b=0x0FCD, start at edge k → busy cycles k+1..k+4; done at k+5 with f=0x2201, cout=0, ovf=0, zero=0.
- Add wrap to zero: op=011, a=0xFFFF, b=0x0001, cin=0 → f=0x0000, cout=1, zero=1, ovf=0. Signed overflow: a=0x7FFF, b=0x0001 → f=0x8000, ovf=1, cout=0.
- Subtract both directions, cin=1:
  - op=010, a=0x0003, b=0x0005 → f=0xFFFE, cout=0 (borrow), ovf=0.
  - op=001, a=0x0010, b=0x0100 → f=0x00F0, cout=1.
- Logic ops: op=110, a=0xF0F0, b=0xFF00, cin=1 → f=0xF000, cout=0, ovf=0. Set op=111 → f=0xFFFF. Clear op=000 → f=0, zero=1.
- Handshake:
  - start held high through RUN → the second request is ignored until DONE.
  - start in the DONE cycle → the new op is accepted; busy rises next cycle.
  - f holds the old result during RUN.
- Reset mid-operation: rst_n low at the second RUN cycle → busy, done, f and flags go to 0 immediately with no done pulse. The first start after release completes normally in NSLICE+1 cycles.

Source files
------------

// File: rtl/nibble_serial_alu_pkg.sv
// Shared ALU definitions: 74x381 function codes, sequencer states and op classification.
package alu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_CLR = 3'b000;
  localparam logic [OP_W-1:0] OP_BSA = 3'b001;
  localparam logic [OP_W-1:0] OP_ASB = 3'b010;
  localparam logic [OP_W-1:0] OP_ADD = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_OR  = 3'b101;
  localparam logic [OP_W-1:0] OP_AND = 3'b110;
  localparam logic [OP_W-1:0] OP_SET = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  function automatic logic is_arith(input logic [OP_W-1:0] op);
    return (op == OP_BSA) || (op == OP_ASB) || (op == OP_ADD);
  endfunction

endpackage

// File: rtl/nibble_serial_alu_if.sv
// Request/result bundle between the datapath controller and the serial ALU.
interface nibble_serial_alu_if
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
);
  logic             start;
  logic [OP_W-1:0]  op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] f;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (output start, op, a, b, cin,
                  input  busy, done, f, cout, ovf, zero);
  modport slave  (input  start, op, a, b, cin,
                  output busy, done, f, cout, ovf, zero);
endinterface

// File: rtl/nibble_serial_alu_slice.sv
// Combinational 74x381-style slice; carry out is only meaningful for arithmetic ops.
module alu_slice
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0]    i_a,
  input  logic [W-1:0]    i_b,
  input  logic [OP_W-1:0] i_op,
  input  logic            i_c,
  output logic [W-1:0]    o_f,
  output logic            o_cout
);
  logic [W:0] w_sum;
  logic [W:0] w_c_ext;

  assign w_c_ext = {{W{1'b0}}, i_c};

  always_comb begin
    w_sum  = '0;
    o_f    = '0;
    o_cout = 1'b0;
    case (i_op)
      OP_CLR: o_f = '0;
      OP_BSA: w_sum = {1'b0, i_b} + {1'b0, ~i_a} + w_c_ext;
      OP_ASB: w_sum = {1'b0, i_a} + {1'b0, ~i_b} + w_c_ext;
      OP_ADD: w_sum = {1'b0, i_a} + {1'b0, i_b} + w_c_ext;
      OP_XOR: o_f = i_a ^ i_b;
      OP_OR:  o_f = i_a | i_b;
      OP_AND: o_f = i_a & i_b;
      default: o_f = '1;
    endcase
    if (is_arith(i_op)) begin
      o_f    = w_sum[W-1:0];
      o_cout = w_sum[W];
    end
  end
endmodule

// File: rtl/nibble_serial_alu.sv
// WIDTH-bit ALU built from one SLICE_W-bit slice, LSB slice first, carry chained through r_carry.
module nibble_serial_alu
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SLICE_W = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  nibble_serial_alu_if.slave  bus
);
  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t           r_state, w_state_next;
  logic [WIDTH-1:0] r_a_sh, r_b_sh, r_acc, r_f;
  logic [OP_W-1:0]  r_op;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry, r_a_msb, r_b_msb, r_cout, r_ovf, r_zero;

  logic               w_accept, w_last, w_slice_cout, w_f_msb, w_ovf;
  logic [SLICE_W-1:0] w_slice_f;
  logic [WIDTH-1:0]   w_acc_next;

  alu_slice #(.W(SLICE_W)) u_slice (
    .i_a    (r_a_sh[SLICE_W-1:0]),
    .i_b    (r_b_sh[SLICE_W-1:0]),
    .i_op   (r_op),
    .i_c    (r_carry),
    .o_f    (w_slice_f),
    .o_cout (w_slice_cout)
  );

  assign w_accept   = bus.start && (r_state != RUN);
  assign w_last     = (r_state == RUN) && (r_idx == IDX_W'(NSLICE - 1));
  // New slice enters at the top so that after NSLICE shifts slice 0 sits at the LSB.
  assign w_acc_next = (WIDTH'(w_slice_f) << (WIDTH - SLICE_W)) | (r_acc >> SLICE_W);
  assign w_f_msb    = w_slice_f[SLICE_W-1];

  always_comb begin
    w_ovf = 1'b0;
    case (r_op)
      OP_ADD: w_ovf = (r_a_msb == r_b_msb) && (w_f_msb != r_a_msb);
      OP_ASB: w_ovf = (r_a_msb != r_b_msb) && (w_f_msb != r_a_msb);
      OP_BSA: w_ovf = (r_a_msb != r_b_msb) && (w_f_msb != r_b_msb);
      default: w_ovf = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = RUN;
      RUN:     if (w_last)    w_state_next = DONE;
      DONE:    w_state_next = bus.start ? RUN : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_acc   <= '0;
      r_op    <= OP_CLR;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_f     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= bus.a;
      r_b_sh  <= bus.b;
      r_op    <= bus.op;
      r_idx   <= '0;
      r_carry <= is_arith(bus.op) ? bus.cin : 1'b0;
      r_a_msb <= bus.a[WIDTH-1];
      r_b_msb <= bus.b[WIDTH-1];
    end else if (r_state == RUN) begin
      r_a_sh  <= r_a_sh >> SLICE_W;
      r_b_sh  <= r_b_sh >> SLICE_W;
      r_acc   <= w_acc_next;
      r_carry <= w_slice_cout;
      r_idx   <= w_last ? '0 : r_idx + 1'b1;
      if (w_last) begin
        r_f    <= w_acc_next;
        r_cout <= is_arith(r_op) ? w_slice_cout : 1'b0;
        r_ovf  <= w_ovf;
        r_zero <= (w_acc_next == '0);
      end
    end
  end

  assign bus.busy = (r_state == RUN);
  assign bus.done = (r_state == DONE);
  assign bus.f    = r_f;
  assign bus.cout = r_cout;
  assign bus.ovf  = r_ovf;
  assign bus.zero = r_zero;
endmodule

// File: tb/tb_nibble_serial_alu.sv
// Directed bench for nibble_serial_alu (WIDTH=16, SLICE_W=4) with hand-computed expectations.
module tb_nibble_serial_alu;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   n_assert;
  int   n_fail;

  nibble_serial_alu_if #(.WIDTH(16)) bus ();

  nibble_serial_alu #(.WIDTH(16), .SLICE_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one request and checks the busy/done timeline; returns in the done cycle.
  task automatic do_op(input string tag, input logic [2:0] op_i, input logic [15:0] a_i,
                       input logic [15:0] b_i, input logic cin_i, input logic [15:0] prev_f);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op_i;
    bus.a     = a_i;
    bus.b     = b_i;
    bus.cin   = cin_i;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk({tag, ".busy"}, 16'(bus.busy), 16'd1);
      chk({tag, ".hold_f"}, bus.f, prev_f);
      @(posedge clk); #1;
    end
    chk({tag, ".done"}, 16'(bus.done), 16'd1);
    chk({tag, ".busy_lo"}, 16'(bus.busy), 16'd0);
  endtask

  task automatic chk_res(input string tag, input logic [15:0] f_e, input logic c_e,
                         input logic o_e, input logic z_e);
    chk({tag, ".f"}, bus.f, f_e);
    chk({tag, ".cout"}, 16'(bus.cout), 16'(c_e));
    chk({tag, ".ovf"}, 16'(bus.ovf), 16'(o_e));
    chk({tag, ".zero"}, 16'(bus.zero), 16'(z_e));
    $display("op %s f=%h cout=%b ovf=%b zero=%b", tag, bus.f, bus.cout, bus.ovf, bus.zero);
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.op    = OP_CLR;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", 16'(bus.busy), 16'd0);
    chk("rst.done", 16'(bus.done), 16'd0);
    chk_res("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("add1", OP_ADD, 16'h1234, 16'h0FCD, 1'b0, 16'h0000);
    chk_res("add1", 16'h2201, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("idle.done", 16'(bus.done), 16'd0);
    chk("idle.busy", 16'(bus.busy), 16'd0);
    chk("idle.f", bus.f, 16'h2201);

    do_op("addwrap", OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 16'h2201);
    chk_res("addwrap", 16'h0000, 1'b1, 1'b0, 1'b1);
    do_op("addovf", OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 16'h0000);
    chk_res("addovf", 16'h8000, 1'b0, 1'b1, 1'b0);
    do_op("addcin", OP_ADD, 16'h0001, 16'h0001, 1'b1, 16'h8000);
    chk_res("addcin", 16'h0003, 1'b0, 1'b0, 1'b0);
    do_op("asb", OP_ASB, 16'h0003, 16'h0005, 1'b1, 16'h0003);
    chk_res("asb", 16'hFFFE, 1'b0, 1'b0, 1'b0);
    do_op("bsa", OP_BSA, 16'h0010, 16'h0100, 1'b1, 16'hFFFE);
    chk_res("bsa", 16'h00F0, 1'b1, 1'b0, 1'b0);
    do_op("asbovf", OP_ASB, 16'h8000, 16'h0001, 1'b1, 16'h00F0);
    chk_res("asbovf", 16'h7FFF, 1'b1, 1'b1, 1'b0);
    do_op("and", OP_AND, 16'hF0F0, 16'hFF00, 1'b1, 16'h7FFF);
    chk_res("and", 16'hF000, 1'b0, 1'b0, 1'b0);
    do_op("xor", OP_XOR, 16'hF0F0, 16'hFF00, 1'b1, 16'hF000);
    chk_res("xor", 16'h0FF0, 1'b0, 1'b0, 1'b0);
    do_op("or", OP_OR, 16'hF0F0, 16'hFF00, 1'b1, 16'h0FF0);
    chk_res("or", 16'hFFF0, 1'b0, 1'b0, 1'b0);
    do_op("set", OP_SET, 16'h1234, 16'h5678, 1'b1, 16'hFFF0);
    chk_res("set", 16'hFFFF, 1'b0, 1'b0, 1'b0);
    do_op("clr", OP_CLR, 16'h1234, 16'h5678, 1'b1, 16'hFFFF);
    chk_res("clr", 16'h0000, 1'b0, 1'b0, 1'b1);

    // start held high: the request changing mid-RUN must be ignored, the one seen in DONE accepted.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_ADD;
    bus.a     = 16'h0001;
    bus.b     = 16'h0001;
    bus.cin   = 1'b0;
    @(posedge clk); #1;
    bus.a = 16'h0005;
    for (int i = 0; i < 4; i++) begin
      chk("hold.busy", 16'(bus.busy), 16'd1);
      chk("hold.nodone", 16'(bus.done), 16'd0);
      @(posedge clk); #1;
    end
    chk("hold.done", 16'(bus.done), 16'd1);
    chk_res("hold1", 16'h0002, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("b2b.busy", 16'(bus.busy), 16'd1);
    chk("b2b.nodone", 16'(bus.done), 16'd0);
    chk("b2b.hold_f", bus.f, 16'h0002);
    for (int i = 0; i < 4; i++) begin
      chk("b2b.run", 16'(bus.busy), 16'd1);
      @(posedge clk); #1;
    end
    chk("b2b.done", 16'(bus.done), 16'd1);
    chk_res("b2b", 16'h0006, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("b2b.idle", 16'(bus.done), 16'd0);

    // Reset in the second RUN cycle abandons the operation.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_ADD;
    bus.a     = 16'hFFFF;
    bus.b     = 16'h0001;
    bus.cin   = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("mid.busy", 16'(bus.busy), 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid.busy_lo", 16'(bus.busy), 16'd0);
    chk("mid.done_lo", 16'(bus.done), 16'd0);
    chk_res("midrst", 16'h0000, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("post.nodone", 16'(bus.done), 16'd0);
      chk("post.nobusy", 16'(bus.busy), 16'd0);
    end
    do_op("post", OP_ADD, 16'h1234, 16'h0FCD, 1'b0, 16'h0000);
    chk_res("post", 16'h2201, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
